fht_unload: RTL and testbench

- Read-out engine for fht_top: the reader side of the 4-bank result RAM interface (iADDR_RD_0..3 / oDATA_0..3).
- Triggered after the transform completes.
- Sweeps all rows in bit-reversed address order, so the result leaves in natural order.
- Serialises the four banks into one word stream with valid/ready backpressure.
- Sits between fht_top and the downstream consumer (IFHT loader, DMA, host).

---
 rtl/fht_pkg.sv | 22 ++
 rtl/fht_row_fifo.sv | 70 +++++++
 rtl/fht_unload.sv | 139 +++++++++++++
 tb/tb_fht_unload.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fht_pkg.sv
// Shared types and helpers for the FHT result read-out path.
package fht_pkg;

  localparam int BANK_NUM = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Reverse the low w bits of v; bits above w come back as zero.
  function automatic logic [31:0] bit_rev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fht_row_fifo.sv
// Two-entry row FIFO: four bank words plus the row index they were read from.
module fht_row_fifo
  import fht_pkg::*;
#(
  parameter int D_BIT = 22,
  parameter int A_BIT = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push_i,
  input  logic [BANK_NUM-1:0][D_BIT-1:0]     row_i,
  input  logic [A_BIT-1:0]                   tag_i,
  input  logic                               pop_i,
  output logic [BANK_NUM-1:0][D_BIT-1:0]     row_o,
  output logic [A_BIT-1:0]                   tag_o,
  output logic                               full_o,
  output logic                               empty_o,
  output logic [1:0]                         count_o
);

  logic [BANK_NUM-1:0][D_BIT-1:0] row_q [2];
  logic [BANK_NUM-1:0][D_BIT-1:0] row_d [2];
  logic [A_BIT-1:0]               tag_q [2];
  logic [A_BIT-1:0]               tag_d [2];
  logic                           wr_q, wr_d, rd_q, rd_d;
  logic [1:0]                     cnt_q, cnt_d;
  logic                           do_push, do_pop;

  always_comb begin
    row_d   = row_q;
    tag_d   = tag_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    // A push into a full FIFO is only taken when the head leaves on the same edge.
    do_push = push_i && ((cnt_q != 2'd2) || pop_i);
    do_pop  = pop_i && (cnt_q != 2'd0);
    if (do_push) begin
      row_d[wr_q] = row_i;
      tag_d[wr_q] = tag_i;
      wr_d        = ~wr_q;
    end
    if (do_pop) rd_d = ~rd_q;
    cnt_d = cnt_q + 2'(do_push) - 2'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        row_q[i] <= '0;
        tag_q[i] <= '0;
      end
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      row_q <= row_d;
      tag_q <= tag_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign row_o   = row_q[rd_q];
  assign tag_o   = tag_q[rd_q];
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign count_o = cnt_q;

endmodule

// File: rtl/fht_unload.sv
// Reads the four result banks in bit-reversed row order and streams the words
// out in natural order over a valid/ready handshake.
module fht_unload
  import fht_pkg::*;
#(
  parameter int D_BIT  = 22,
  parameter int A_BIT  = 8,
  parameter int RD_LAT = 2
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic               iSTART,
  input  logic [D_BIT-1:0]   iDATA_0,
  input  logic [D_BIT-1:0]   iDATA_1,
  input  logic [D_BIT-1:0]   iDATA_2,
  input  logic [D_BIT-1:0]   iDATA_3,
  output logic [A_BIT-1:0]   oADDR_RD_0,
  output logic [A_BIT-1:0]   oADDR_RD_1,
  output logic [A_BIT-1:0]   oADDR_RD_2,
  output logic [A_BIT-1:0]   oADDR_RD_3,
  output logic [D_BIT-1:0]   oDATA,
  output logic [A_BIT+1:0]   oINDEX,
  output logic               oVALID,
  input  logic               iREADY,
  output logic               oBUSY,
  output logic               oDONE
);

  localparam logic [A_BIT-1:0] LAST_ROW = {A_BIT{1'b1}};

  state_t                      state_q, state_d;
  logic [A_BIT:0]              j_q, j_d;
  logic [A_BIT-1:0]            addr_q, addr_d;
  logic [RD_LAT:0]             vld_q, vld_d;
  logic [RD_LAT:0][A_BIT-1:0]  jtag_q, jtag_d;
  logic [1:0]                  bank_q, bank_d;

  logic                            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [1:0]                      fifo_count;
  logic [BANK_NUM-1:0][D_BIT-1:0]  push_row, head_row;
  logic [A_BIT-1:0]                head_tag;

  logic             issue_start, issue_run, issue, hs, last_hs;
  logic [A_BIT-1:0] row;
  logic [3:0]       inflight, pending;

  assign push_row  = {iDATA_3, iDATA_2, iDATA_1, iDATA_0};
  assign fifo_push = vld_q[RD_LAT];

  fht_row_fifo #(
    .D_BIT (D_BIT),
    .A_BIT (A_BIT)
  ) u_fifo (
    .clk     (iCLK),
    .rst     (iRESET),
    .push_i  (fifo_push),
    .row_i   (push_row),
    .tag_i   (jtag_q[RD_LAT]),
    .pop_i   (fifo_pop),
    .row_o   (head_row),
    .tag_o   (head_tag),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    hs       = ~fifo_empty & iREADY;
    fifo_pop = hs & (bank_q == 2'd3);
    last_hs  = fifo_pop & (head_tag == LAST_ROW);

    inflight = '0;
    for (int i = 0; i <= RD_LAT; i++) inflight = inflight + 4'(vld_q[i]);
    pending = 4'(fifo_count) + inflight;

    // Counting the pop on this edge lets the next read start early enough to
    // keep the stream gap-free even at the longest read latency.
    issue_start = (state_q == IDLE) & iSTART;
    issue_run   = (state_q == RUN) & ~j_q[A_BIT] & ~(fifo_full & ~fifo_pop) &
                  ((pending < 4'd2) | ((pending == 4'd2) & fifo_pop));
    issue       = issue_start | issue_run;
    row         = issue_start ? '0 : j_q[A_BIT-1:0];

    j_d    = j_q;
    addr_d = addr_q;
    if (issue_start)    j_d = (A_BIT+1)'(1);
    else if (issue_run) j_d = j_q + 1'b1;
    if (issue) addr_d = A_BIT'(bit_rev(32'(row), A_BIT));

    vld_d  = {vld_q[RD_LAT-1:0], issue};
    jtag_d = {jtag_q[RD_LAT-1:0], row};
    bank_d = hs ? bank_q + 2'd1 : bank_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (iSTART)  state_d = RUN;
      RUN:     if (last_hs) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      j_q    <= '0;
      addr_q <= '0;
      vld_q  <= '0;
      jtag_q <= '0;
      bank_q <= '0;
    end else begin
      j_q    <= j_d;
      addr_q <= addr_d;
      vld_q  <= vld_d;
      jtag_q <= jtag_d;
      bank_q <= bank_d;
    end
  end

  always_comb begin
    oBUSY  = (state_q == RUN);
    oDONE  = (state_q == DONE);
    oVALID = ~fifo_empty;
    oDATA  = head_row[bank_q];
    oINDEX = {head_tag, bank_q};
  end

  assign oADDR_RD_0 = addr_q;
  assign oADDR_RD_1 = addr_q;
  assign oADDR_RD_2 = addr_q;
  assign oADDR_RD_3 = addr_q;

endmodule

// File: tb/tb_fht_unload.sv
// Bench: four unload builds (latency 2/1/3 with 8-bit rows, latency 2 with 2-bit rows)
// fed from a bank RAM model and checked every cycle against a stream model.
module tb_fht_unload;

  localparam int NI = 4;
  localparam int DB = 22;
  localparam int LAT       [NI] = '{2, 1, 3, 2};
  localparam int AB        [NI] = '{8, 8, 8, 2};
  localparam int FIRST_LIT [NI] = '{4, 3, 5, 4};
  // Completed unloads per build in each phase: plain, random ready, start held, reset.
  localparam int DONE_LIT [4][NI] = '{'{1, 1, 1, 2}, '{1, 1, 1, 1}, '{1, 1, 1, 3}, '{1, 1, 1, 2}};
  localparam logic [31:0] CAP_LIT [4] = '{32'h00010080, 32'h000300FF, 32'h00000002, 32'h00000001};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic ready = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] a_data [NI];
  logic [31:0] a_index [NI];
  logic [31:0] a_addr [NI][4];
  logic        a_valid [NI];
  logic        a_busy [NI];
  logic        a_done [NI];
  logic        a_ovf [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_cfg
    localparam int L = LAT[gi];
    localparam int A = AB[gi];
    logic [A-1:0]  addr [4];
    logic [DB-1:0] rdat [4];
    logic [DB-1:0] o_data;
    logic [A+1:0]  o_index;
    logic          o_valid, o_busy, o_done;

    // Bank b row a holds (b<<16)|a, delivered L cycles after the address.
    for (genvar gb = 0; gb < 4; gb++) begin : g_bank
      logic [A-1:0] pipe [3];
      always @(posedge clk) begin
        pipe[0] <= addr[gb];
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
      end
      assign rdat[gb] = DB'((32'(gb) << 16) | 32'(pipe[L-1]));
      assign a_addr[gi][gb] = 32'(addr[gb]);
    end

    fht_unload #(.D_BIT(DB), .A_BIT(A), .RD_LAT(L)) u_dut (
      .iCLK       (clk),
      .iRESET     (rst),
      .iSTART     (start),
      .iDATA_0    (rdat[0]),
      .iDATA_1    (rdat[1]),
      .iDATA_2    (rdat[2]),
      .iDATA_3    (rdat[3]),
      .oADDR_RD_0 (addr[0]),
      .oADDR_RD_1 (addr[1]),
      .oADDR_RD_2 (addr[2]),
      .oADDR_RD_3 (addr[3]),
      .oDATA      (o_data),
      .oINDEX     (o_index),
      .oVALID     (o_valid),
      .iREADY     (ready),
      .oBUSY      (o_busy),
      .oDONE      (o_done)
    );

    assign a_data[gi]  = 32'(o_data);
    assign a_index[gi] = 32'(o_index);
    assign a_valid[gi] = o_valid;
    assign a_busy[gi]  = o_busy;
    assign a_done[gi]  = o_done;
    assign a_ovf[gi]   = u_dut.fifo_push & u_dut.fifo_full & ~u_dut.fifo_pop;
  end

  function automatic int brev(input int v, input int w);
    int r = 0;
    for (int i = 0; i < w; i++) if ((v >> i) & 1) r |= 1 << (w - 1 - i);
    return r;
  endfunction

  function automatic logic [31:0] word_of(input int k, input int w);
    return 32'(((k % 4) << 16) | brev(k / 4, w));
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0h want=%0h", nm, inst, cyc, act, exp);
    end
  endtask

  // Model state, owned by the compare process only.
  bit          exp_busy [NI], exp_done [NI], stall [NI], got_first [NI];
  int          k [NI], start_cyc [NI], done_cnt [NI], snap [NI], first_rel [NI];
  logic [31:0] prev_data [NI], prev_index [NI];
  logic [31:0] cap [4];
  int          phase_end = 0, phase_seen = 0, to_cnt = 0, to_seen = 0;

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      int  total;
      bit  hs, acc, nd, ev;
      total = 4 * (1 << AB[i]);
      if (rst) begin
        chk("rst_valid", i, 32'(a_valid[i]), 32'd0);
        chk("rst_busy",  i, 32'(a_busy[i]),  32'd0);
        chk("rst_done",  i, 32'(a_done[i]),  32'd0);
        chk("rst_data",  i, a_data[i],  32'd0);
        chk("rst_index", i, a_index[i], 32'd0);
        chk("rst_addr",  i, a_addr[i][0] | a_addr[i][1] | a_addr[i][2] | a_addr[i][3], 32'd0);
        exp_busy[i] = 0; exp_done[i] = 0; stall[i] = 0; k[i] = 0;
      end else begin
        ev = exp_busy[i] && (cyc >= start_cyc[i] + LAT[i] + 2);
        chk("busy",  i, 32'(a_busy[i]),  32'(exp_busy[i]));
        chk("done",  i, 32'(a_done[i]),  32'(exp_done[i]));
        chk("valid", i, 32'(a_valid[i]), 32'(ev));
        chk("addr_eq", i, {a_addr[i][1] ^ a_addr[i][0]} | {a_addr[i][2] ^ a_addr[i][0]} |
                          {a_addr[i][3] ^ a_addr[i][0]}, 32'd0);
        chk("overflow", i, 32'(a_ovf[i]), 32'd0);
        if (a_valid[i]) begin
          chk("index", i, a_index[i], 32'(k[i]));
          chk("data",  i, a_data[i],  word_of(k[i], AB[i]));
          if (stall[i]) begin
            chk("hold_data",  i, a_data[i],  prev_data[i]);
            chk("hold_index", i, a_index[i], prev_index[i]);
          end
          if (!got_first[i] && exp_busy[i]) begin
            first_rel[i] = cyc - start_cyc[i];
            got_first[i] = 1;
          end
        end
        hs  = a_valid[i] && ready;
        acc = start && !exp_busy[i] && !exp_done[i];
        nd  = 0;
        if (hs && exp_busy[i]) begin
          if (phase_seen == 0) begin
            if (i == 0 && k[i] == 5)    cap[0] = a_data[i];
            if (i == 0 && k[i] == 1023) cap[1] = a_data[i];
            if (i == 3 && k[i] == 4)    cap[2] = a_data[i];
            if (i == 3 && k[i] == 8)    cap[3] = a_data[i];
          end
          k[i]++;
          if (k[i] == total) begin
            exp_busy[i] = 0;
            nd = 1;
            $display("unload inst=%0d rd_lat=%0d a_bit=%0d words=%0d end_cyc=%0d",
                     i, LAT[i], AB[i], k[i], cyc);
          end
        end
        if (acc) begin
          exp_busy[i] = 1; k[i] = 0; start_cyc[i] = cyc; got_first[i] = 0;
        end
        exp_done[i] = nd;
        if (a_done[i]) done_cnt[i]++;
        stall[i]      = a_valid[i] && !ready;
        prev_data[i]  = a_data[i];
        prev_index[i] = a_index[i];
      end
    end

    if (to_cnt != to_seen) begin
      chk("idle_timeout", 0, 32'(to_cnt), 32'(to_seen));
      to_seen = to_cnt;
    end
    if (phase_end != phase_seen) begin
      for (int i = 0; i < NI; i++) begin
        chk("done_count", i, 32'(done_cnt[i] - snap[i]), 32'(DONE_LIT[phase_seen][i]));
        snap[i] = done_cnt[i];
        if (phase_seen == 0) chk("first_valid", i, 32'(first_rel[i]), 32'(FIRST_LIT[i]));
      end
      if (phase_seen == 0)
        for (int c = 0; c < 4; c++) chk("lit_word", c, cap[c], CAP_LIT[c]);
      phase_seen++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd);
    bit idle;
    bit hit = 0;
    for (int n = 0; n < 6000; n++) begin
      if (rnd) ready = 1'($urandom_range(0, 1));
      step();
      idle = 1;
      for (int i = 0; i < NI; i++) if (a_busy[i] || a_done[i]) idle = 0;
      if (idle) begin
        hit = 1;
        break;
      end
    end
    ready = 1'b1;
    if (!hit) to_cnt++;
    step();
  endtask

  initial begin
    for (int c = 0; c < 4; c++) cap[c] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step(); step();

    // Plain unload, start re-pulsed around word 100.
    pulse();
    repeat (103) step();
    pulse();
    wait_idle(0);
    phase_end++;
    step();

    // Random backpressure.
    pulse();
    wait_idle(1);
    phase_end++;
    step();

    // Start held high: the short build restarts right after each DONE.
    start = 1'b1;
    repeat (60) step();
    start = 1'b0;
    wait_idle(0);
    phase_end++;
    step();

    // Reset in the middle of an unload, then a fresh unload.
    pulse();
    repeat (503) step();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    pulse();
    wait_idle(0);
    phase_end++;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
